// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, sequences one registered ROM read per
// instruction and presents the captured byte to the control unit via valid/ack.
module fetch_unit #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_halt,
   input  logic              i_jump,
   input  logic [ADDR_W-1:0] i_jump_addr,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic              o_rom_enable,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic [DATA_W-1:0] o_instr,
   output logic              o_instr_valid,
   input  logic              i_instr_ack,
   output logic [ADDR_W-1:0] o_pc
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_READ  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                enable_q, enable_d;

   // State and output registers; reset clears enable/valid immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         pc_q     <= PC_INIT;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         enable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         enable_q <= enable_d;
      end
   end

   // Next-state logic; the ROM bus is only looked at in READ so a floating bus is harmless.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         S_IDLE: begin
            if (!i_halt) begin
               state_d = S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            state_d = S_READ;
         end
         S_READ: begin
            instr_d = i_rom_data;
            pc_d    = pc_q + PC_ONE;
            state_d = S_VALID;
         end
         S_VALID: begin
            if (i_instr_ack) begin
               if (i_jump) begin
                  pc_d = i_jump_addr;
               end else begin
                  pc_d = pc_q;
               end
               if (i_halt) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ADDR;
               end
            end else begin
               state_d = S_VALID;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      enable_d = (state_d == S_ADDR) || (state_d == S_READ);
      valid_d  = (state_d == S_VALID);
   end

   assign o_rom_addr    = pc_q;
   assign o_pc          = pc_q;
   assign o_rom_enable  = enable_q;
   assign o_instr       = instr_q;
   assign o_instr_valid = valid_q;

endmodule
